// File: rtl/baud_divider.sv
// rtl/baud_divider.sv - programmable baud prescaler with oversample, mid-bit and end-of-bit ticks
//
// Purpose: divides the clock by (div_q+1) to make an oversample tick, then
// counts OVERSAMPLE of those per bit to mark the mid-bit sample point and
// the end of each bit.
//
// Ports:
//   in       - clock, all state updates on its rising edge
//   rst      - asynchronous active-high reset
//   en       - count enable
//   div      - new divisor, captured into div_q when load is high
//   load     - capture div and realign phase
//   restart  - realign phase to zero, keep divisor
//   tick_os  - one-cycle oversample tick
//   tick_mid - one-cycle mid-bit tick
//   tick_bit - one-cycle end-of-bit tick
//   count    - current prescaler value
//   os_count - current oversample index

module baud_divider #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 867,
  parameter int OVERSAMPLE  = 16,
  parameter int OS_WIDTH    = 4
) (
  input  logic                in,
  input  logic                rst,
  input  logic                en,
  input  logic [WIDTH-1:0]    div,
  input  logic                load,
  input  logic                restart,
  output logic                tick_os,
  output logic                tick_mid,
  output logic                tick_bit,
  output logic [WIDTH-1:0]    count,
  output logic [OS_WIDTH-1:0] os_count
);

  localparam logic [WIDTH-1:0]    DIV_RESET = WIDTH'(DEFAULT_DIV);
  localparam logic [OS_WIDTH-1:0] OS_LAST   = OS_WIDTH'(OVERSAMPLE - 1);
  localparam logic [OS_WIDTH-1:0] OS_MID    = OS_WIDTH'(OVERSAMPLE / 2 - 1);

  logic [WIDTH-1:0] div_q;

  always_ff @(posedge in or posedge rst) begin
    if (rst) begin
      div_q    <= DIV_RESET;
      count    <= '0;
      os_count <= '0;
      tick_os  <= 1'b0;
      tick_mid <= 1'b0;
      tick_bit <= 1'b0;
    end else begin
      // Ticks are pulses: cleared on every edge unless the enabled wrap
      // branch below raises them again.
      tick_os  <= 1'b0;
      tick_mid <= 1'b0;
      tick_bit <= 1'b0;
      if (load) begin
        div_q    <= div;
        count    <= '0;
        os_count <= '0;
      end else if (restart) begin
        count    <= '0;
        os_count <= '0;
      end else if (en) begin
        // >= rather than == so a count left above a smaller divisor still
        // wraps instead of running up to the top of the counter.
        if (count >= div_q) begin
          count   <= '0;
          tick_os <= 1'b1;
          // tick_mid looks at the index before it advances, so it fires
          // half a bit ahead of tick_bit.
          tick_mid <= (os_count == OS_MID);
          if (os_count == OS_LAST) begin
            os_count <= '0;
            tick_bit <= 1'b1;
          end else begin
            os_count <= os_count + OS_WIDTH'(1);
          end
        end else begin
          count <= count + WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_baud_divider.sv
// tb/tb_baud_divider.sv - self-checking bench for baud_divider
module tb_baud_divider;

  localparam int W   = 4;
  localparam int DD  = 6;
  localparam int OS  = 4;
  localparam int OSW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic [W-1:0]   div = '0;
  logic           load = 1'b0;
  logic           restart = 1'b0;
  logic           tick_os, tick_mid, tick_bit;
  logic [W-1:0]   count;
  logic [OSW-1:0] os_count;

  baud_divider #(.WIDTH(W), .DEFAULT_DIV(DD), .OVERSAMPLE(OS), .OS_WIDTH(OSW)) dut (
    .in(clk), .rst(rst), .en(en), .div(div), .load(load), .restart(restart),
    .tick_os(tick_os), .tick_mid(tick_mid), .tick_bit(tick_bit),
    .count(count), .os_count(os_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: k = enabled edges since last realignment, d = active divisor.
  // Phase and ticks follow from division of k by the tick period.
  int k = 0;
  int d = DD;
  bit adv = 1'b0;

  function automatic logic [W-1:0] m_cnt();
    return W'(k % (d + 1));
  endfunction
  function automatic logic [OSW-1:0] m_os();
    return OSW'((k / (d + 1)) % OS);
  endfunction
  function automatic logic m_tos();
    return adv && (k % (d + 1) == 0);
  endfunction
  function automatic logic m_tmid();
    return m_tos() && ((k / (d + 1)) % OS == OS / 2);
  endfunction
  function automatic logic m_tbit();
    return m_tos() && ((k / (d + 1)) % OS == 0);
  endfunction

  task automatic step(input logic e, input logic l, input logic r, input logic [W-1:0] dv);
    @(negedge clk);
    en = e; load = l; restart = r; div = dv;
    @(posedge clk);
    if (l) begin d = int'(dv); k = 0; adv = 1'b0; end
    else if (r) begin k = 0; adv = 1'b0; end
    else if (e) begin k++; adv = 1'b1; end
    else adv = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({tick_os, tick_mid, tick_bit, count, os_count} !== '0) begin
      errors++;
      $display("FAIL reset_state: got %b/%b/%b cnt=%0d os=%0d, need all zero",
               tick_os, tick_mid, tick_bit, count, os_count);
    end
    @(negedge clk); rst = 1'b0;
    k = 0; d = DD; adv = 1'b0;
    // default divisor shows up as tick spacing of DD+1
    for (int i = 1; i <= DD + 1; i++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      checks++;
      if (tick_os !== (i == DD + 1)) begin
        errors++;
        $display("FAIL reset_default_div edge %0d: tick_os=%b need %b", i, tick_os, i == DD + 1);
      end
    end
  endtask

  task automatic test_div3();
    step(1'b0, 1'b1, 1'b0, W'(3));
    for (int i = 1; i <= 32; i++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      checks++;
      if ({tick_os, tick_mid, tick_bit, count, os_count} !== {m_tos(), m_tmid(), m_tbit(), m_cnt(), m_os()}) begin
        errors++;
        $display("FAIL div3 edge %0d: got os/mid/bit=%b%b%b cnt=%0d osc=%0d need %b%b%b cnt=%0d osc=%0d",
                 i, tick_os, tick_mid, tick_bit, count, os_count,
                 m_tos(), m_tmid(), m_tbit(), m_cnt(), m_os());
      end
      checks++;
      if (tick_os !== (i % 4 == 0) || tick_mid !== (i % 16 == 8) || tick_bit !== (i % 16 == 0)) begin
        errors++;
        $display("FAIL div3_const edge %0d: got %b%b%b", i, tick_os, tick_mid, tick_bit);
      end
    end
  endtask

  task automatic test_div0();
    step(1'b0, 1'b1, 1'b0, W'(0));
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      checks++;
      if (tick_os !== 1'b1 || tick_mid !== (i % 4 == 2) || tick_bit !== (i % 4 == 0)) begin
        errors++;
        $display("FAIL div0 edge %0d: got os/mid/bit=%b%b%b need 1%b%b",
                 i, tick_os, tick_mid, tick_bit, i % 4 == 2, i % 4 == 0);
      end
    end
  endtask

  task automatic test_load_midcount();
    step(1'b0, 1'b1, 1'b0, W'(12));
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (count !== W'(10)) begin
      errors++; $display("FAIL load_pre: count=%0d need 10", count);
    end
    step(1'b1, 1'b1, 1'b0, W'(5));
    checks++;
    if (count !== '0 || {tick_os, tick_mid, tick_bit} !== 3'b000) begin
      errors++; $display("FAIL load_mid: count=%0d ticks=%b%b%b need 0/000", count, tick_os, tick_mid, tick_bit);
    end
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      checks++;
      if (tick_os !== (i == 6)) begin
        errors++; $display("FAIL load_first_tick edge %0d: tick_os=%b need %b", i, tick_os, i == 6);
      end
    end
  endtask

  task automatic test_restart();
    int n;
    step(1'b0, 1'b1, 1'b0, W'(2));
    n = 0;
    while (m_os() != OSW'(3) && n < 100) begin
      step(1'b1, 1'b0, 1'b0, '0);
      n++;
    end
    checks++;
    if (os_count !== OSW'(3)) begin
      errors++; $display("FAIL restart_reach: os_count=%0d need 3 after %0d edges", os_count, n);
    end
    step(1'b1, 1'b0, 1'b1, '0);
    checks++;
    if (count !== '0 || os_count !== '0 || {tick_os, tick_mid, tick_bit} !== 3'b000) begin
      errors++; $display("FAIL restart: cnt=%0d os=%0d ticks=%b%b%b need 0/0/000",
                         count, os_count, tick_os, tick_mid, tick_bit);
    end
    step(1'b1, 1'b1, 1'b1, W'(5));
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      checks++;
      if (tick_os !== (i == 6)) begin
        errors++; $display("FAIL load_over_restart edge %0d: tick_os=%b need %b", i, tick_os, i == 6);
      end
    end
  endtask

  task automatic test_en_hold();
    logic [W-1:0]   fc;
    logic [OSW-1:0] fo;
    step(1'b0, 1'b1, 1'b0, W'(9));
    for (int i = 0; i < 25; i++) step(1'b1, 1'b0, 1'b0, '0);
    fc = m_cnt(); fo = m_os();
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b0, 1'b0, '0);
      checks++;
      if (count !== fc || os_count !== fo || {tick_os, tick_mid, tick_bit} !== 3'b000) begin
        errors++; $display("FAIL en_hold cyc %0d: cnt=%0d os=%0d ticks=%b%b%b need %0d/%0d/000",
                           i, count, os_count, tick_os, tick_mid, tick_bit, fc, fo);
      end
    end
    step(1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (count !== m_cnt() || os_count !== m_os()) begin
      errors++; $display("FAIL en_resume: cnt=%0d os=%0d need %0d/%0d", count, os_count, m_cnt(), m_os());
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, 1'b1, 1'b0, W'(1));
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, '0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({tick_os, tick_mid, tick_bit, count, os_count} !== '0) begin
      errors++; $display("FAIL async_reset: ticks=%b%b%b cnt=%0d os=%0d need zero",
                         tick_os, tick_mid, tick_bit, count, os_count);
    end
    @(negedge clk); en = 1'b0; load = 1'b0; restart = 1'b0;
    @(negedge clk); rst = 1'b0;
    k = 0; d = DD; adv = 1'b0;
    for (int i = 1; i <= (DD + 1) * OS; i++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      checks++;
      if (tick_bit !== (i == (DD + 1) * OS) || tick_os !== (i % (DD + 1) == 0)) begin
        errors++; $display("FAIL post_reset edge %0d: tick_os=%b tick_bit=%b", i, tick_os, tick_bit);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 39) == 0, W'($urandom_range(0, 15)));
      checks++;
      if ({tick_os, tick_mid, tick_bit, count, os_count} !== {m_tos(), m_tmid(), m_tbit(), m_cnt(), m_os()}) begin
        errors++;
        $display("FAIL random cyc %0d: got %b%b%b cnt=%0d os=%0d need %b%b%b cnt=%0d os=%0d",
                 i, tick_os, tick_mid, tick_bit, count, os_count,
                 m_tos(), m_tmid(), m_tbit(), m_cnt(), m_os());
      end
    end
  endtask

  initial begin
    test_reset();
    test_div3();
    test_div0();
    test_load_midcount();
    test_restart();
    test_en_hold();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
